// File: rtl/pad_scan_ctrl.sv
// Serial game-pad scanner: latches the pad shift register, clocks out NBITS bits, publishes the frame.
// Optional macro PAD_SCAN_DEBOUNCE_EN: publish a frame only when it matches the previous frame.
module pad_scan_ctrl #(
  parameter int CLK_DIV  = 250,
  parameter int NBITS    = 16,
  parameter int POLL_DIV = 833333
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             scan_en,
  input  logic             data_in,
  output logic             latch,
  output logic             pulse,
  output logic [NBITS-1:0] buttons,
  output logic             frame_vld,
  output logic [1:0]       dir,
  output logic             dir_vld,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    PULSE_HI = 3'd2,
    PULSE_LO = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(NBITS);
  localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);

  state_t           state;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [PW-1:0]    poll_cnt;
  logic             first_pend;
  logic [NBITS-1:0] shadow;
  logic [NBITS-1:0] shadow_upd;
  logic             start_frame;
  logic             frame_accept;
  logic [1:0]       dir_code;
  logic [1:0]       dir_q;

  assign state_dbg   = state;
  assign start_frame = scan_en && (first_pend || (poll_cnt == POLL_LAST));

  // Shadow as it will look once the bit currently being sampled is merged in.
  always_comb begin
    shadow_upd          = shadow;
    shadow_upd[bit_cnt] = ~data_in;
  end

`ifdef PAD_SCAN_DEBOUNCE_EN
  logic [NBITS-1:0] prev_shadow;
  assign frame_accept = (shadow_upd == prev_shadow);
`else
  assign frame_accept = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      poll_cnt   <= '0;
      first_pend <= 1'b1;
      shadow     <= '0;
      latch      <= 1'b0;
      pulse      <= 1'b0;
      buttons    <= '0;
      frame_vld  <= 1'b0;
`ifdef PAD_SCAN_DEBOUNCE_EN
      prev_shadow <= '0;
`endif
    end else begin
      frame_vld <= 1'b0;
      if (poll_cnt != POLL_LAST) poll_cnt <= poll_cnt + 1'b1;

      case (state)
        IDLE, DONE: begin
          // DONE may chain straight into the next frame when polling is faster than a frame.
          if (start_frame) begin
            state      <= LATCH;
            latch      <= 1'b1;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            poll_cnt   <= '0;
            first_pend <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end

        LATCH: begin
          if (div_cnt == DIV_LAST) begin
            shadow  <= shadow_upd;
            div_cnt <= '0;
            bit_cnt <= BW'(1);
            latch   <= 1'b0;
            pulse   <= 1'b1;
            state   <= PULSE_HI;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        PULSE_HI: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            pulse   <= 1'b0;
            state   <= PULSE_LO;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        PULSE_LO: begin
          if (div_cnt == DIV_LAST) begin
            shadow  <= shadow_upd;
            div_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              // Outputs are registered, so buttons and frame_vld are valid during DONE.
              state <= DONE;
              if (frame_accept) begin
                buttons   <= shadow_upd;
                frame_vld <= 1'b1;
              end
`ifdef PAD_SCAN_DEBOUNCE_EN
              prev_shadow <= shadow_upd;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              pulse   <= 1'b1;
              state   <= PULSE_HI;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          latch <= 1'b0;
          pulse <= 1'b0;
        end
      endcase
    end
  end

  // Direction decode: up > down > left > right; last code is held when nothing is pressed.
  always_comb begin
    dir_vld = |buttons[7:4];
    if (buttons[4])      dir_code = 2'd0;
    else if (buttons[5]) dir_code = 2'd1;
    else if (buttons[6]) dir_code = 2'd2;
    else                 dir_code = 2'd3;
    dir = dir_vld ? dir_code : dir_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q <= 2'd0;
    end else if (dir_vld) begin
      dir_q <= dir_code;
    end
  end

endmodule

// File: tb/tb_pad_scan_ctrl.sv
// Directed bench for pad_scan_ctrl: a behavioural pad shift register feeds data_in,
// frame results are checked against hand-computed values through an expected queue.
module tb_pad_scan_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int NBITS     = 16;
  localparam int POLL_DIV  = 200;
  localparam int FRAME_LEN = CLK_DIV * (2 * NBITS - 1) + 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             scan_en = 1'b0;
  logic             data_in;
  logic             latch;
  logic             pulse;
  logic [NBITS-1:0] buttons;
  logic             frame_vld;
  logic [1:0]       dir;
  logic             dir_vld;
  logic [2:0]       state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = 0;
  int prev_start = 0;

  logic [NBITS-1:0] pad = '0;
  int               sh_idx = 0;
  logic             pulse_d = 1'b0;
  logic [NBITS-1:0] exp_q[$];

  pad_scan_ctrl #(
    .CLK_DIV (CLK_DIV),
    .NBITS   (NBITS),
    .POLL_DIV(POLL_DIV)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .scan_en  (scan_en),
    .data_in  (data_in),
    .latch    (latch),
    .pulse    (pulse),
    .buttons  (buttons),
    .frame_vld(frame_vld),
    .dir      (dir),
    .dir_vld  (dir_vld),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Pad shift register: latch loads bit 0, each pulse rising edge advances one bit.
  always @(posedge clk) begin
    pulse_d <= pulse;
    if (latch) sh_idx <= 0;
    else if (pulse && !pulse_d) sh_idx <= sh_idx + 1;
  end
  assign data_in = (sh_idx < NBITS) ? ~pad[sh_idx[3:0]] : 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    scan_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_latch(input string tag, output int vld_seen, output bit ok);
    int n;
    n = 0;
    vld_seen = 0;
    while (latch !== 1'b1 && n < 4 * POLL_DIV) begin
      @(negedge clk);
      n++;
      if (frame_vld === 1'b1) vld_seen++;
    end
    ok = (latch === 1'b1);
    if (!ok) check({tag, "_latch_timeout"}, 32'd0, 32'd1);
    prev_start = last_start;
    last_start = cyc;
  endtask

  task automatic wait_bit(input string tag, input int idx);
    int n;
    n = 0;
    while (sh_idx != idx && n < FRAME_LEN) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_bit_reached"}, sh_idx, idx);
  endtask

`ifndef PAD_SCAN_DEBOUNCE_EN
  // Observes one whole frame from the first latch cycle (cycle 0) to frame_vld.
  task automatic measure_frame(input string tag);
    int   vld_pre, latch_n, pulse_n, edges, overlap, vld_at;
    bit   ok;
    logic pp;
    wait_latch(tag, vld_pre, ok);
    if (!ok) return;
    check({tag, "_vld_before"}, vld_pre, 0);
    latch_n = 0; pulse_n = 0; edges = 0; overlap = 0; vld_at = -1; pp = 1'b0;
    for (int c = 0; c < FRAME_LEN + 20 && vld_at < 0; c++) begin
      if (c > 0) @(negedge clk);
      latch_n += int'(latch);
      pulse_n += int'(pulse);
      if (pulse && !pp) edges++;
      pp = pulse;
      if (latch && pulse) overlap++;
      if (frame_vld) vld_at = c;
    end
    check({tag, "_latch_cycles"}, latch_n, CLK_DIV);
    check({tag, "_pulse_edges"}, edges, NBITS - 1);
    check({tag, "_pulse_cycles"}, pulse_n, CLK_DIV * (NBITS - 1));
    check({tag, "_overlap"}, overlap, 0);
    check({tag, "_vld_cycle"}, vld_at, FRAME_LEN - 1);
    check({tag, "_exp_q_nonempty"}, exp_q.size(), 1);
    if (exp_q.size() > 0) check({tag, "_buttons"}, buttons, exp_q.pop_front());
  endtask

  task automatic run_scan();
    int  vld_pre, n, lat;
    bit  ok;
    @(negedge clk);
    reset_n = 1'b1;
    scan_en = 1'b1;

    pad = 16'h0000; exp_q.push_back(16'h0000);
    measure_frame("f0");
    check("f0_dir_vld", dir_vld, 1'b0);

    pad = 16'h0090; exp_q.push_back(16'h0090);
    measure_frame("f1");
    check("f1_period", last_start - prev_start, POLL_DIV);
    check("f1_dir", dir, 2'd0);
    check("f1_dir_vld", dir_vld, 1'b1);

    pad = 16'h0040; exp_q.push_back(16'h0040);
    measure_frame("f2");
    check("f2_dir", dir, 2'd2);
    check("f2_dir_vld", dir_vld, 1'b1);

    pad = 16'h0080; exp_q.push_back(16'h0080);
    measure_frame("f3");
    check("f3_dir", dir, 2'd3);

    pad = 16'h0000; exp_q.push_back(16'h0000);
    measure_frame("f4");
    check("f4_dir_vld", dir_vld, 1'b0);
    check("f4_dir_hold", dir, 2'd3);

    // scan_en dropped mid-frame: this frame finishes, nothing follows
    pad = 16'h0010; exp_q.push_back(16'h0010);
    wait_latch("f5", vld_pre, ok);
    wait_bit("f5", 5);
    scan_en = 1'b0;
    n = 0;
    while (frame_vld !== 1'b1 && n < 2 * FRAME_LEN) begin
      @(negedge clk);
      n++;
    end
    check("f5_vld", frame_vld, 1'b1);
    check("f5_buttons", buttons, exp_q.pop_front());
    lat = 0;
    repeat (2 * POLL_DIV) begin
      @(negedge clk);
      lat += int'(latch);
    end
    check("f5_no_latch", lat, 0);

    // reset during bit 9 aborts the frame
    scan_en = 1'b1;
    pad = 16'h0020;
    wait_latch("f6", vld_pre, ok);
    wait_bit("f6", 9);
    reset_n = 1'b0;
    #1;
    check("f6_rst_latch", latch, 1'b0);
    check("f6_rst_pulse", pulse, 1'b0);
    check("f6_rst_buttons", buttons, 16'h0000);
    check("f6_rst_vld", frame_vld, 1'b0);
    check("f6_rst_dir", dir, 2'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(16'h0020);
    measure_frame("f7");
    check("f7_dir", dir, 2'd1);
    check("f7_dir_vld", dir_vld, 1'b1);
  endtask
`else
  localparam logic [NBITS-1:0] DB_PAT [3] = '{16'h0010, 16'h0020, 16'h0020};
  localparam logic [NBITS-1:0] DB_BTN [3] = '{16'h0000, 16'h0000, 16'h0020};
  localparam int               DB_VLD [3] = '{0, 0, 1};

  task automatic run_debounce();
    int vld_pre, vld_n;
    bit ok;
    pad = DB_PAT[0];
    @(negedge clk);
    reset_n = 1'b1;
    scan_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pad = DB_PAT[i];
      exp_q.push_back(DB_BTN[i]);
      wait_latch("db", vld_pre, ok);
      vld_n = 0;
      repeat (FRAME_LEN + 5) begin
        vld_n += int'(frame_vld);
        @(negedge clk);
      end
      check($sformatf("db%0d_vld", i), vld_n, DB_VLD[i]);
      check($sformatf("db%0d_buttons", i), buttons, exp_q.pop_front());
    end
  endtask
`endif

  initial begin
    apply_reset();
    check("rst_latch", latch, 1'b0);
    check("rst_pulse", pulse, 1'b0);
    check("rst_buttons", buttons, 16'h0000);
    check("rst_vld", frame_vld, 1'b0);
    check("rst_dir", dir, 2'd0);
    check("rst_dir_vld", dir_vld, 1'b0);
    check("rst_state", state_dbg, 3'd0);
`ifdef PAD_SCAN_DEBOUNCE_EN
    run_debounce();
`else
    run_scan();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
